// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for the data MMU: size/sign decode, lane steering,
// stall hold with timeout, and aligned/extended load return. One access in flight.
module load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_datain,
    output logic        mmu_wen,
    output logic        mmu_ren,
    output logic [3:0]  mmu_bsel,
    input  logic        mmu_nostall,
    input  logic [31:0] mmu_dataout
);

    // state  | meaning
    // IDLE   | ready for a new request
    // ACCESS | MMU request driven, waiting for mmu_nostall
    // RESP   | one-cycle response pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t           state;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] stall_cnt;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  bsel_next;
    logic [31:0] datain_next;
    logic [31:0] lane_word;
    logic [31:0] load_result;

    always_comb begin
        illegal = 1'b0;
        if (req_we)
            illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            illegal = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11);

        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        bsel_next   = 4'b1111;
        datain_next = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                bsel_next   = 4'b0001 << req_addr[1:0];
                datain_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                bsel_next   = 4'b0011 << req_addr[1:0];
                datain_next = {2{req_wdata[15:0]}};
            end
            default: begin
                bsel_next   = 4'b1111;
                datain_next = req_wdata;
            end
        endcase
    end

    always_comb begin
        lane_word   = mmu_dataout >> {off_q, 3'b000};
        load_result = lane_word;
        case (f3_q)
            3'b000:  load_result = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_result = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_result = {24'd0, lane_word[7:0]};
            3'b101:  load_result = {16'd0, lane_word[15:0]};
            default: load_result = lane_word;
        endcase
        if (we_q)
            load_result = 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 2'b00;
            mmu_addr   <= 32'd0;
            mmu_datain <= 32'd0;
            mmu_wen    <= 1'b0;
            mmu_ren    <= 1'b0;
            mmu_bsel   <= 4'd0;
            stall_cnt  <= '0;
            we_q       <= 1'b0;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        req_ready <= 1'b0;
                        // funct3 legality takes priority over alignment
                        if (illegal || misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= illegal ? 2'b10 : 2'b01;
                            resp_rdata <= 32'd0;
                        end else begin
                            state      <= ACCESS;
                            stall_cnt  <= '0;
                            mmu_addr   <= {req_addr[31:2], 2'b00};
                            mmu_bsel   <= bsel_next;
                            mmu_datain <= datain_next;
                            mmu_wen    <= req_we;
                            mmu_ren    <= !req_we;
                        end
                    end
                end
                ACCESS: begin
                    if (mmu_nostall) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b00;
                        resp_rdata <= load_result;
                        mmu_wen    <= 1'b0;
                        mmu_ren    <= 1'b0;
                        mmu_bsel   <= 4'd0;
                    end else if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b11;
                        resp_rdata <= 32'd0;
                        mmu_wen    <= 1'b0;
                        mmu_ren    <= 1'b0;
                        mmu_bsel   <= 4'd0;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_datain;
    logic        mmu_wen;
    logic        mmu_ren;
    logic [3:0]  mmu_bsel;
    logic        mmu_nostall;
    logic [31:0] mmu_dataout;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mmu_addr(mmu_addr), .mmu_datain(mmu_datain), .mmu_wen(mmu_wen),
        .mmu_ren(mmu_ren), .mmu_bsel(mmu_bsel), .mmu_nostall(mmu_nostall),
        .mmu_dataout(mmu_dataout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Expected result of one request, derived from byte-level rules
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word, input int stalls,
                         output logic [1:0] err, output logic [31:0] rd,
                         output logic [3:0] bsel, output logic [31:0] din);
        int off, size;
        logic legal;
        longint v;
        off   = int'(addr[1:0]);
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << (int'(f3) % 4);
        bsel  = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++)
            din[8*i +: 8] = wdata[8*(i % size) +: 8];
        v = longint'(word >> (8 * off)) & ((64'sd1 << (8 * size)) - 1);
        if (f3 < 3'd4 && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
            v = v - (64'sd1 << (8 * size));
        rd = we ? 32'd0 : v[31:0];
        if (!legal)                err = 2'b10;
        else if (off % size != 0)  err = 2'b01;
        else if (stalls >= TO)     err = 2'b11;
        else                       err = 2'b00;
        if (err != 2'b00) rd = 32'd0;
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word, input int stalls);
        logic [1:0]  e_err;
        logic [31:0] e_rd, e_din;
        logic [3:0]  e_bsel;
        int          waited;
        model(we, f3, addr, wdata, word, stalls, e_err, e_rd, e_bsel, e_din);
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_before_req", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom();
        req_wdata  = $urandom();
        if (e_err == 2'b01 || e_err == 2'b10) begin
            check("err_path_valid", resp_valid, 1'b1);
            check("err_path_code", resp_err, e_err);
            check("err_path_rdata", resp_rdata, 32'd0);
            check("err_path_en", {mmu_ren, mmu_wen}, 2'b00);
        end else begin
            for (int i = 0; i < TO; i++) begin
                check("acc_ren", mmu_ren, !we);
                check("acc_wen", mmu_wen, we);
                check("acc_addr", mmu_addr, {addr[31:2], 2'b00});
                check("acc_bsel", mmu_bsel, e_bsel);
                check("acc_datain", mmu_datain, e_din);
                check("acc_ready", req_ready, 1'b0);
                check("acc_no_resp", resp_valid, 1'b0);
                mmu_nostall = (i >= stalls);
                mmu_dataout = (i >= stalls) ? word : $urandom();
                @(posedge clk); #1;
                mmu_nostall = 1'b0;
                if (i >= stalls) break;
            end
            check("resp_valid", resp_valid, 1'b1);
            check("resp_err", resp_err, e_err);
            check("resp_rdata", resp_rdata, e_rd);
            check("resp_en_off", {mmu_ren, mmu_wen}, 2'b00);
        end
        @(posedge clk); #1;
        check("resp_one_cycle", resp_valid, 1'b0);
        check("ready_after", req_ready, 1'b1);
        check("held_err", resp_err, e_err);
        check("held_rdata", resp_rdata, e_rd);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        mmu_nostall = 1'b0; mmu_dataout = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_resp", {resp_valid, resp_err}, 3'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_en", {mmu_wen, mmu_ren}, 2'b00);
        check("rst_bsel", mmu_bsel, 4'd0);
        check("rst_addr", mmu_addr, 32'd0);
        check("rst_datain", mmu_datain, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0);
        run_req(1'b1, 3'b001, 32'h0000_0202, 32'hABCD_5678, 32'd0, 0);
        run_req(1'b0, 3'b010, 32'h0000_0301, 32'd0, 32'd0, 0);
        run_req(1'b0, 3'b011, 32'h0000_0300, 32'd0, 32'd0, 0);
        run_req(1'b1, 3'b100, 32'h0000_0301, 32'd0, 32'd0, 0);
        run_req(1'b0, 3'b101, 32'h0000_0402, 32'd0, 32'h9ABC_0000, 3);
        run_req(1'b0, 3'b010, 32'h0000_0500, 32'd0, 32'h1234_5678, TO);
        run_req(1'b0, 3'b010, 32'h0000_0504, 32'd0, 32'hCAFE_F00D, 0);

        // Reset in the middle of an access
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0600;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("pre_rst_ren", mmu_ren, 1'b1);
        reset = 1'b1;
        #2;
        check("midrst_ren", mmu_ren, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_no_resp", resp_valid, 1'b0);
        run_req(1'b0, 3'b010, 32'h0000_0700, 32'd0, 32'h0BAD_BEEF, 0);

        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [2:0]  f3;
            int          st;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            st = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 2))
                                             : int'($urandom_range(0, 3));
            run_req(we, f3, $urandom(), $urandom(), $urandom(), st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
